// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file for the 5-stage pipeline.
// Two combinational read ports with same-cycle write-through, plus a commit counter.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] Do_5,
  input  logic [DW-1:0] ALUout_5,
  input  logic [4:0]    rw_5,
  input  logic          MemtoReg_5,
  input  logic          RegWr_5,
  input  logic [4:0]    ra,
  input  logic [4:0]    rb,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  output logic [DW-1:0] busW,
  output logic [31:0]   wb_cnt
);

  // Register 0 is a constant, so storage starts at index 1.
  logic [DW-1:0] regs [1:NREG-1];
  logic [31:0]   cnt_q;
  logic          we;

  assign busW   = MemtoReg_5 ? Do_5 : ALUout_5;
  assign we     = RegWr_5 && (rw_5 != 5'd0) && (int'(rw_5) < NREG);
  assign wb_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      cnt_q <= '0;
    end else if (we) begin
      regs[rw_5] <= busW;
      cnt_q      <= cnt_q + 32'd1;
    end
  end

  // Bypass is deliberately not gated by reset; upstream flushes the pipeline.
  always_comb begin
    busA = '0;
    if (ra != 5'd0) begin
      if (we && (rw_5 == ra)) begin
        busA = busW;
      end else if (int'(ra) < NREG) begin
        busA = regs[ra];
      end
    end
  end

  always_comb begin
    busB = '0;
    if (rb != 5'd0) begin
      if (we && (rw_5 == rb)) begin
        busB = busW;
      end else if (int'(rb) < NREG) begin
        busB = regs[rb];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against a behavioural array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Do_5, ALUout_5;
  logic [4:0]  rw_5, ra, rb;
  logic        MemtoReg_5, RegWr_5;
  logic [31:0] busA, busB, busW, wb_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;
  logic [31:0] saved_cnt;

  always #5 clk = ~clk;

  wb_regfile #(.NREG(32), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Do_5       (Do_5),
    .ALUout_5   (ALUout_5),
    .rw_5       (rw_5),
    .MemtoReg_5 (MemtoReg_5),
    .RegWr_5    (RegWr_5),
    .ra         (ra),
    .rb         (rb),
    .busA       (busA),
    .busB       (busB),
    .busW       (busW),
    .wb_cnt     (wb_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_w();
    return MemtoReg_5 ? Do_5 : ALUout_5;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (RegWr_5 && rw_5 != 5'd0 && rw_5 == addr) return exp_w();
    return model_regs[addr];
  endfunction

  // Called at a falling edge with inputs already applied; checks, then crosses one rising edge.
  task automatic cycle();
    #1;
    chk("busW", busW, exp_w());
    chk("busA", busA, exp_read(ra));
    chk("busB", busB, exp_read(rb));
    chk("wb_cnt", wb_cnt, model_cnt);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_cnt = 32'h0;
    end else if (RegWr_5 && rw_5 != 5'd0) begin
      model_regs[rw_5] = exp_w();
      model_cnt        = model_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    RegWr_5 = 1'b0; MemtoReg_5 = 1'b0; rw_5 = 5'd0;
    Do_5 = 32'h0; ALUout_5 = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; ra = 5'd0; rb = 5'd0;
    idle();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state over all addresses
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      #1;
      chk("rst_busA", busA, 32'h0);
      chk("rst_busB", busB, 32'h0);
      cycle();
    end
    chk("rst_cnt", wb_cnt, 32'h0);

    // Simple write then read through the array
    RegWr_5 = 1'b1; ALUout_5 = 32'h12345678; rw_5 = 5'd5;
    cycle();
    idle(); ra = 5'd5;
    #1;
    chk("wr_busA", busA, 32'h12345678);
    chk("wr_cnt", wb_cnt, 32'd1);
    cycle();

    // Memory select plus same-cycle bypass on both ports
    RegWr_5 = 1'b1; MemtoReg_5 = 1'b1; Do_5 = 32'hCAFEBABE; ALUout_5 = 32'h1;
    rw_5 = 5'd9; ra = 5'd9; rb = 5'd9;
    #1;
    chk("byp_busW", busW, 32'hCAFEBABE);
    chk("byp_busA", busA, 32'hCAFEBABE);
    chk("byp_busB", busB, 32'hCAFEBABE);
    cycle();
    idle();
    #1;
    chk("arr_r9", busA, 32'hCAFEBABE);
    cycle();

    // Write to register zero is discarded and not counted
    saved_cnt = wb_cnt;
    RegWr_5 = 1'b1; rw_5 = 5'd0; ALUout_5 = 32'hFFFFFFFF; ra = 5'd0; rb = 5'd0;
    #1;
    chk("r0_before", busA, 32'h0);
    cycle();
    idle();
    #1;
    chk("r0_after", busA, 32'h0);
    chk("r0_cnt", wb_cnt, saved_cnt);
    cycle();

    // Write disabled: no bypass, no update
    RegWr_5 = 1'b1; rw_5 = 5'd3; ALUout_5 = 32'hA;
    cycle();
    saved_cnt = wb_cnt;
    RegWr_5 = 1'b0; rw_5 = 5'd3; ALUout_5 = 32'hB; ra = 5'd3;
    #1;
    chk("wd_busA", busA, 32'hA);
    cycle();
    #1;
    chk("wd_after", busA, 32'hA);
    chk("wd_cnt", wb_cnt, saved_cnt);
    cycle();

    // Reset dominates a colliding write
    rst_n = 1'b0; RegWr_5 = 1'b1; rw_5 = 5'd7; ALUout_5 = 32'h55; ra = 5'd7;
    #1;
    chk("rc_bypass", busA, 32'h55);
    cycle();
    rst_n = 1'b1; idle(); ra = 5'd7; rb = 5'd3;
    #1;
    chk("rc_r7", busA, 32'h0);
    chk("rc_r3", busB, 32'h0);
    chk("rc_cnt", wb_cnt, 32'h0);
    cycle();

    // Counter wrap via deposit
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 32'hFFFFFFFF;
    RegWr_5 = 1'b1; rw_5 = 5'd12; ALUout_5 = 32'h77;
    cycle();
    idle();
    #1;
    chk("wrap_cnt", wb_cnt, 32'h0);
    cycle();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      RegWr_5    = $urandom_range(0, 3) != 0;
      MemtoReg_5 = $urandom_range(0, 1) == 1;
      Do_5       = $urandom;
      ALUout_5   = $urandom;
      rw_5       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ra         = ($urandom_range(0, 3) == 0) ? rw_5 : 5'($urandom_range(0, 31));
      rb         = ($urandom_range(0, 3) == 0) ? rw_5 : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
